mem_port_arbiter: RTL and testbench

Shares the single synchronous-read memory port between the fetch stage (read-only requester F) and the memory stage (read/write requester D) of the pipelined OTTER core. Grants one request per cycle, with data priority and a starvation guard for fetch. Routes the one-cycle-late read data back to the owner. Also drops a fetch response that the pipeline has flushed.

---
 rtl/otter_arb_pkg.sv | 15 +
 rtl/arb_starve_ctr.sv | 39 +++
 rtl/mem_port_arbiter.sv | 112 +++++++++++
 tb/tb_mem_port_arbiter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/otter_arb_pkg.sv
// Shared types and constants for the OTTER memory port arbiter.
package otter_arb_pkg;

    // Which requester the read data on the memory port belongs to this cycle.
    typedef enum logic [1:0] {
        NONE  = 2'd0,
        FETCH = 2'd1,
        DLOAD = 2'd2
    } owner_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive denied fetch cycles; STARVED is decoded
// from the registered count so it never depends on this cycle's grant.
module arb_starve_ctr #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic REQ,
    input  logic GNT,
    output logic STARVED
);

    localparam logic [3:0] MAX_CNT = 4'(STARVE_MAX);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // Count denied cycles, clear on grant or when fetch stops asking.
    always_comb begin
        cnt_d = cnt_q;
        if (!REQ || GNT) begin
            cnt_d = 4'd0;
        end else if (cnt_q != MAX_CNT) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    // Counter register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign STARVED = (cnt_q == MAX_CNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous-read memory port between fetch (read-only) and the
// data stage (read/write). Data has priority unless fetch has been starved.
module mem_port_arbiter
    import otter_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              F_REQ,
    input  logic [ADDR_W-1:0] F_ADDR,
    input  logic              F_FLUSH,
    output logic              F_GNT,
    output logic              F_RVALID,
    output logic [31:0]       F_RDATA,
    input  logic              D_REQ,
    input  logic              D_WE,
    input  logic [ADDR_W-1:0] D_ADDR,
    input  logic [31:0]       D_WDATA,
    input  logic [1:0]        D_SIZE,
    input  logic              D_SIGN,
    output logic              D_GNT,
    output logic              D_RVALID,
    output logic [31:0]       D_RDATA,
    output logic              M_EN,
    output logic              M_WE,
    output logic [ADDR_W-1:0] M_ADDR,
    output logic [31:0]       M_WDATA,
    output logic [1:0]        M_SIZE,
    output logic              M_SIGN,
    input  logic [31:0]       M_RDATA,
    output logic              F_STARVED
);

    owner_t owner_q;
    owner_t owner_d;
    logic   f_win;
    logic   d_win;
    logic   f_starved;

    arb_starve_ctr #(
        .STARVE_MAX(STARVE_MAX)
    ) u_starve (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .REQ    (F_REQ),
        .GNT    (f_win),
        .STARVED(f_starved)
    );

    // Arbitration: starved fetch first, then data, then fetch. The raw wins
    // feed the registers (held in reset anyway); the outputs are reset-gated
    // so no request leaks onto the port while RST_N is low.
    always_comb begin
        f_win = F_REQ && (f_starved || !D_REQ);
        d_win = D_REQ && !(f_starved && F_REQ);
        F_GNT = RST_N && f_win;
        D_GNT = RST_N && d_win;
    end

    // Command mux: winner's fields drive the memory port, idle port is all-zero.
    always_comb begin
        M_EN    = 1'b0;
        M_WE    = 1'b0;
        M_ADDR  = '0;
        M_WDATA = 32'd0;
        M_SIZE  = 2'd0;
        M_SIGN  = 1'b0;
        if (F_GNT) begin
            M_EN   = 1'b1;
            M_ADDR = F_ADDR;
            M_SIZE = SIZE_WORD;
        end else if (D_GNT) begin
            M_EN    = 1'b1;
            M_WE    = D_WE;
            M_ADDR  = D_ADDR;
            M_WDATA = D_WDATA;
            M_SIZE  = D_SIZE;
            M_SIGN  = D_SIGN;
        end
    end

    // Next owner of the read data arriving one cycle later; stores get none.
    always_comb begin
        owner_d = NONE;
        if (f_win) begin
            owner_d = FETCH;
        end else if (d_win && !D_WE) begin
            owner_d = DLOAD;
        end
    end

    // Owner register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            owner_q <= NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    // Response steering; a flush only kills the fetch response due now.
    always_comb begin
        F_RVALID  = RST_N && (owner_q == FETCH) && !F_FLUSH;
        D_RVALID  = RST_N && (owner_q == DLOAD);
        F_RDATA   = F_RVALID ? M_RDATA : 32'd0;
        D_RDATA   = D_RVALID ? M_RDATA : 32'd0;
        F_STARVED = RST_N && f_starved;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        f_req;
    logic [31:0] f_addr;
    logic        f_flush;
    logic        f_gnt;
    logic        f_rvalid;
    logic [31:0] f_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [1:0]  d_size;
    logic        d_sign;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        m_en;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [1:0]  m_size;
    logic        m_sign;
    logic [31:0] m_rdata;
    logic        f_starved;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    mem_port_arbiter #(.ADDR_W(32), .STARVE_MAX(4)) dut (
        .CLK(clk), .RST_N(rst_n),
        .F_REQ(f_req), .F_ADDR(f_addr), .F_FLUSH(f_flush), .F_GNT(f_gnt),
        .F_RVALID(f_rvalid), .F_RDATA(f_rdata),
        .D_REQ(d_req), .D_WE(d_we), .D_ADDR(d_addr), .D_WDATA(d_wdata),
        .D_SIZE(d_size), .D_SIGN(d_sign), .D_GNT(d_gnt),
        .D_RVALID(d_rvalid), .D_RDATA(d_rdata),
        .M_EN(m_en), .M_WE(m_we), .M_ADDR(m_addr), .M_WDATA(m_wdata),
        .M_SIZE(m_size), .M_SIGN(m_sign), .M_RDATA(m_rdata),
        .F_STARVED(f_starved)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read word memory; preloaded while reset is held.
    logic [31:0] mem [0:4095];
    always @(posedge clk) begin
        if (!rst_n) begin
            mem[12'h040] <= 32'h00500093;
            mem[12'h041] <= 32'h00A00113;
            mem[12'h800] <= 32'h12345678;
        end else if (m_en) begin
            if (m_we) mem[m_addr[13:2]] <= m_wdata;
            m_rdata <= mem[m_addr[13:2]];
        end
    end

    typedef struct {
        logic        fr;  logic [31:0] fa;  logic ff;
        logic        dr;  logic dw;  logic [31:0] da;  logic [31:0] dwd;
        logic [1:0]  ds;  logic dsg;
        logic        efg; logic edg; logic emen; logic emwe;
        logic [31:0] ema; logic [31:0] emwd; logic [1:0] ems; logic emsg;
        logic        efrv; logic [31:0] efrd; logic edrv; logic [31:0] edrd;
        logic        estv;
    } vec_t;

    localparam logic O = 1'b0;
    localparam logic I = 1'b1;
    localparam logic [31:0] Z = 32'h0;
    localparam logic [1:0] B = 2'd0;
    localparam logic [1:0] W = 2'd2;

    vec_t vecs [21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d actual %h required %h", name, cyc, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        f_req = v.fr; f_addr = v.fa; f_flush = v.ff;
        d_req = v.dr; d_we = v.dw; d_addr = v.da; d_wdata = v.dwd;
        d_size = v.ds; d_sign = v.dsg;
    endtask

    initial begin
        //            fr fa         ff  dr dw da         dwd           ds dsg | fg dg en we ma         mwd           ms msg frv frd           drv drd           stv
        vecs[0]  = '{I, 32'h104, O,  I, O, 32'h2000, Z,            B, O,   O, I, I, O, 32'h2000, Z,            B, O,  O, Z,            O, Z,            O};
        vecs[1]  = '{I, 32'h104, O,  O, O, Z,        Z,            B, O,   I, O, I, O, 32'h104,  Z,            W, O,  O, Z,            I, 32'h12345678, O};
        vecs[2]  = '{I, 32'h100, O,  O, O, Z,        Z,            B, O,   I, O, I, O, 32'h100,  Z,            W, O,  I, 32'h00A00113, O, Z,            O};
        vecs[3]  = '{O, Z,       I,  O, O, Z,        Z,            B, O,   O, O, O, O, Z,        Z,            B, O,  O, Z,            O, Z,            O};
        vecs[4]  = '{I, 32'h100, O,  O, O, Z,        Z,            B, O,   I, O, I, O, 32'h100,  Z,            W, O,  O, Z,            O, Z,            O};
        vecs[5]  = '{I, 32'h104, I,  O, O, Z,        Z,            B, O,   I, O, I, O, 32'h104,  Z,            W, O,  O, Z,            O, Z,            O};
        vecs[6]  = '{O, Z,       O,  O, O, Z,        Z,            B, O,   O, O, O, O, Z,        Z,            B, O,  I, 32'h00A00113, O, Z,            O};
        vecs[7]  = '{O, Z,       I,  I, I, 32'h3000, 32'hDEADBEEF, W, O,   O, I, I, I, 32'h3000, 32'hDEADBEEF, W, O,  O, Z,            O, Z,            O};
        vecs[8]  = '{O, Z,       O,  I, O, 32'h3000, Z,            W, I,   O, I, I, O, 32'h3000, Z,            W, I,  O, Z,            O, Z,            O};
        vecs[9]  = '{O, Z,       O,  O, O, Z,        Z,            B, O,   O, O, O, O, Z,        Z,            B, O,  O, Z,            I, 32'hDEADBEEF, O};
        for (int i = 10; i < 14; i++)
            vecs[i] = '{I, 32'h100, O, I, I, 32'h3004, 32'hCAFEF00D, W, O,  O, I, I, I, 32'h3004, 32'hCAFEF00D, W, O,  O, Z, O, Z, O};
        vecs[14] = '{I, 32'h100, O,  I, I, 32'h3004, 32'hCAFEF00D, W, O,   I, O, I, O, 32'h100,  Z,            W, O,  O, Z,            O, Z,            I};
        vecs[15] = '{I, 32'h100, O,  I, I, 32'h3004, 32'hCAFEF00D, W, O,   O, I, I, I, 32'h3004, 32'hCAFEF00D, W, O,  I, 32'h00500093, O, Z,            O};
        for (int i = 16; i < 19; i++)
            vecs[i] = '{I, 32'h100, O, I, I, 32'h3004, 32'hCAFEF00D, W, O,  O, I, I, I, 32'h3004, 32'hCAFEF00D, W, O,  O, Z, O, Z, O};
        vecs[19] = '{I, 32'h100, O,  I, I, 32'h3004, 32'hCAFEF00D, W, O,   I, O, I, O, 32'h100,  Z,            W, O,  O, Z,            O, Z,            I};
        vecs[20] = '{O, Z,       O,  O, O, Z,        Z,            B, O,   O, O, O, O, Z,        Z,            B, O,  I, 32'h00500093, O, Z,            O};

        // Reset held with both requesters asking: nothing may reach the port.
        rst_n = 1'b0;
        drive(vecs[0]);
        repeat (3) @(posedge clk);
        @(negedge clk);
        cyc = -1;
        chk("rst_f_gnt", {31'd0, f_gnt}, 32'd0);
        chk("rst_d_gnt", {31'd0, d_gnt}, 32'd0);
        chk("rst_m_en", {31'd0, m_en}, 32'd0);
        chk("rst_m_addr", m_addr, 32'd0);
        chk("rst_f_rvalid", {31'd0, f_rvalid}, 32'd0);
        chk("rst_d_rvalid", {31'd0, d_rvalid}, 32'd0);
        chk("rst_starved", {31'd0, f_starved}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            cyc = i;
            drive(vecs[i]);
            @(negedge clk);
            chk("f_gnt", {31'd0, f_gnt}, {31'd0, vecs[i].efg});
            chk("d_gnt", {31'd0, d_gnt}, {31'd0, vecs[i].edg});
            chk("m_en", {31'd0, m_en}, {31'd0, vecs[i].emen});
            chk("m_we", {31'd0, m_we}, {31'd0, vecs[i].emwe});
            chk("m_addr", m_addr, vecs[i].ema);
            chk("m_wdata", m_wdata, vecs[i].emwd);
            chk("m_size", {30'd0, m_size}, {30'd0, vecs[i].ems});
            chk("m_sign", {31'd0, m_sign}, {31'd0, vecs[i].emsg});
            chk("f_rvalid", {31'd0, f_rvalid}, {31'd0, vecs[i].efrv});
            chk("f_rdata", f_rdata, vecs[i].efrd);
            chk("d_rvalid", {31'd0, d_rvalid}, {31'd0, vecs[i].edrv});
            chk("d_rdata", d_rdata, vecs[i].edrd);
            chk("f_starved", {31'd0, f_starved}, {31'd0, vecs[i].estv});
            @(posedge clk); #1;
        end

        // Reset while a fetch read is outstanding: its response must vanish.
        cyc = 100;
        drive('{I, 32'h104, O, O, O, Z, Z, B, O, O, O, O, O, Z, Z, B, O, O, Z, O, Z, O});
        @(negedge clk);
        chk("mid_f_gnt", {31'd0, f_gnt}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_f_gnt", {31'd0, f_gnt}, 32'd0);
        chk("mid_rst_m_en", {31'd0, m_en}, 32'd0);
        f_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        cyc = 101;
        chk("mid_post_f_rvalid", {31'd0, f_rvalid}, 32'd0);
        chk("mid_post_f_rdata", f_rdata, 32'd0);
        @(posedge clk); #1;
        f_req = 1'b1;
        f_addr = 32'h104;
        @(negedge clk);
        cyc = 102;
        chk("mid_refetch_gnt", {31'd0, f_gnt}, 32'd1);
        @(posedge clk); #1;
        f_req = 1'b0;
        @(negedge clk);
        cyc = 103;
        chk("mid_refetch_rvalid", {31'd0, f_rvalid}, 32'd1);
        chk("mid_refetch_rdata", f_rdata, 32'h00A00113);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
